// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the 9-bit accumulator core.
// Drives the instruction ROM address and resolves BR/BRZ targets through a
// small writable branch table. A taken branch to itself ends the program,
// and a cycle watchdog forces a stop if the program never does that.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | out of reset, waiting for start
// S_RUN  | fetching one instruction per cycle, cycle counter running
// S_DONE | stopped by halt or watchdog, outputs frozen until next start
module fetch_sequencer #(
  parameter int ADDR_W    = 7,
  parameter int LUT_DEPTH = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8:0]        instr_in,
  input  logic              zero_flag,
  input  logic              lut_we,
  input  logic [2:0]        lut_waddr,
  input  logic [ADDR_W-1:0] lut_wdata,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0]  OP_BR   = 3'b110;
  localparam logic [2:0]  OP_BRZ  = 3'b111;
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic              running_q, running_d;
  logic [ADDR_W-1:0] lut_q [LUT_DEPTH];

  logic [2:0]        op;
  logic [2:0]        idx;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic              taken;
  logic              halt;
  logic [15:0]       cnt_inc;
  logic              wd_hit;
  logic              unused_instr_bits;

  // Instruction decode and branch resolution for the current fetch.
  assign op      = instr_in[8:6];
  assign idx     = instr_in[2:0];
  assign target  = lut_q[idx];
  assign taken   = (op == OP_BR) || ((op == OP_BRZ) && zero_flag);
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign pc_next = taken ? target : pc_inc;
  // A taken branch back onto itself is the program's halt idiom.
  assign halt    = taken && (target == pc_q);
  assign cnt_inc = cnt_q + 16'd1;
  assign wd_hit  = (cnt_inc == WD_LIMIT);

  // Operand field bits [5:3] carry no meaning for sequencing.
  assign unused_instr_bits = ^instr_in[5:3];

  // Next-state and next-output logic; everything holds unless changed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (halt) begin
          // Halt beats the watchdog when both land on the same cycle.
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (wd_hit) begin
          state_d = S_DONE;
          pc_d    = pc_next;
          done_d  = 1'b1;
          to_d    = 1'b1;
        end else begin
          pc_d = pc_next;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    running_d = (state_d == S_RUN);
  end

  // Control state, program counter, counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      to_q      <= to_d;
      running_q <= running_d;
    end
  end

  // Branch table writes; a branch reading the entry being written this
  // cycle sees the old contents because there is no bypass path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  assign inst_addr   = pc_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = to_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main instance, default geometry.
  logic       start_m = 1'b0, zero_m = 1'b0, lut_we_m = 1'b0;
  logic [2:0] lut_waddr_m = '0;
  logic [6:0] lut_wdata_m = '0;
  logic [8:0] instr_m;
  logic [6:0] inst_addr_m;
  logic       running_m, done_m, timeout_m;
  logic [15:0] cycle_count_m;
  logic [8:0] rom_m [128];
  assign instr_m = rom_m[inst_addr_m];

  // Small instance: 3-bit address and a 16-cycle watchdog.
  logic       start_s = 1'b0, zero_s = 1'b0, lut_we_s = 1'b0;
  logic [2:0] lut_waddr_s = '0;
  logic [2:0] lut_wdata_s = '0;
  logic [8:0] instr_s;
  logic [2:0] inst_addr_s;
  logic       running_s, done_s, timeout_s;
  logic [15:0] cycle_count_s;
  logic [8:0] rom_s [8];
  assign instr_s = rom_s[inst_addr_s];

  fetch_sequencer dut_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .instr_in(instr_m),
    .zero_flag(zero_m), .lut_we(lut_we_m), .lut_waddr(lut_waddr_m),
    .lut_wdata(lut_wdata_m), .inst_addr(inst_addr_m), .running(running_m),
    .done(done_m), .timeout(timeout_m), .cycle_count(cycle_count_m)
  );

  fetch_sequencer #(.ADDR_W(3), .LUT_DEPTH(8), .TIMEOUT(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .instr_in(instr_s),
    .zero_flag(zero_s), .lut_we(lut_we_s), .lut_waddr(lut_waddr_s),
    .lut_wdata(lut_wdata_s), .inst_addr(inst_addr_s), .running(running_s),
    .done(done_s), .timeout(timeout_s), .cycle_count(cycle_count_s)
  );

  int n_chk = 0;
  int n_fail = 0;
  int sb[$];

  typedef struct {
    int         run;
    logic [6:0] addr;
    logic [8:0] instr;
    logic       z;
    logic       st;
    logic [6:0] nxt;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic lut_write_m(input logic [2:0] a, input logic [6:0] d);
    lut_we_m = 1'b1; lut_waddr_m = a; lut_wdata_m = d;
    @(posedge clk); #1;
    lut_we_m = 1'b0;
  endtask

  task automatic lut_write_s(input logic [2:0] a, input logic [2:0] d);
    lut_we_s = 1'b1; lut_waddr_s = a; lut_wdata_s = d;
    @(posedge clk); #1;
    lut_we_s = 1'b0;
  endtask

  task automatic start_m_pulse();
    start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    chk("start_running", running_m, 1);
    chk("start_addr", inst_addr_m, 0);
    chk("start_count", cycle_count_m, 0);
    chk("start_done", done_m, 0);
    chk("start_timeout", timeout_m, 0);
  endtask

  task automatic run_table(input int r, input int n_cyc, input int halt_addr);
    foreach (vecs[i]) if (vecs[i].run == r) rom_m[vecs[i].addr] = vecs[i].instr;
    start_m_pulse();
    foreach (vecs[i]) begin
      if (vecs[i].run == r) begin
        chk("tbl_cur_addr", inst_addr_m, vecs[i].addr);
        zero_m  = vecs[i].z;
        start_m = vecs[i].st;
        sb.push_back(vecs[i].nxt);
        @(posedge clk); #1;
        start_m = 1'b0;
        chk("tbl_next_addr", inst_addr_m, sb.pop_front());
      end
    end
    chk("tbl_done", done_m, 1);
    chk("tbl_running", running_m, 0);
    chk("tbl_timeout", timeout_m, 0);
    chk("tbl_count", cycle_count_m, n_cyc);
    chk("tbl_halt_addr", inst_addr_m, halt_addr);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, limit 100000 ns");
    $fatal(1, "bench time limit");
  end

  initial begin
    // run 0: straight line, BR 2 halts at 5; start pulses inside RUN ignored
    vecs[0]  = '{0, 7'd0,  9'o010, 1'b0, 1'b0, 7'd1};
    vecs[1]  = '{0, 7'd1,  9'o123, 1'b0, 1'b0, 7'd2};
    vecs[2]  = '{0, 7'd2,  9'o245, 1'b1, 1'b1, 7'd3};
    vecs[3]  = '{0, 7'd3,  9'o367, 1'b0, 1'b0, 7'd4};
    vecs[4]  = '{0, 7'd4,  9'o501, 1'b0, 1'b0, 7'd5};
    vecs[5]  = '{0, 7'd5,  9'o602, 1'b0, 1'b1, 7'd5};
    // run 1: BRZ 1 taken to 10, BR 3 back, BRZ 1 not taken, BR 5 halts at 4
    vecs[6]  = '{1, 7'd0,  9'o000, 1'b0, 1'b0, 7'd1};
    vecs[7]  = '{1, 7'd1,  9'o111, 1'b1, 1'b0, 7'd2};
    vecs[8]  = '{1, 7'd2,  9'o222, 1'b0, 1'b0, 7'd3};
    vecs[9]  = '{1, 7'd3,  9'o701, 1'b1, 1'b0, 7'd10};
    vecs[10] = '{1, 7'd10, 9'o603, 1'b0, 1'b0, 7'd3};
    vecs[11] = '{1, 7'd3,  9'o701, 1'b0, 1'b0, 7'd4};
    vecs[12] = '{1, 7'd4,  9'o605, 1'b1, 1'b0, 7'd4};

    for (int i = 0; i < 128; i++) rom_m[i] = 9'o000;
    for (int i = 0; i < 8; i++) rom_s[i] = 9'o000;

    // asynchronous reset in the middle of the low phase
    #2 rst_n = 1'b0;
    #1;
    chk("rst_addr", inst_addr_m, 0);
    chk("rst_running", running_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_timeout", timeout_m, 0);
    chk("rst_count", cycle_count_m, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (20) @(posedge clk);
    #1;
    chk("idle_addr", inst_addr_m, 0);
    chk("idle_running", running_m, 0);
    chk("idle_done", done_m, 0);

    // straight line with halt, then DONE holds
    lut_write_m(3'd2, 7'd5);
    run_table(0, 6, 5);
    @(posedge clk); #1;
    chk("done_hold", done_m, 1);
    chk("done_hold_addr", inst_addr_m, 5);
    chk("done_hold_count", cycle_count_m, 6);

    // BRZ both ways, restarted from DONE
    lut_write_m(3'd1, 7'd10);
    lut_write_m(3'd3, 7'd3);
    lut_write_m(3'd5, 7'd4);
    run_table(1, 7, 4);

    // LUT write in the same cycle as a branch reading that entry
    lut_write_m(3'd4, 7'd11);
    lut_write_m(3'd6, 7'd20);
    rom_m[0]  = 9'o604;
    rom_m[11] = 9'o604;
    rom_m[20] = 9'o606;
    start_m_pulse();
    lut_we_m = 1'b1; lut_waddr_m = 3'd4; lut_wdata_m = 7'd20;
    @(posedge clk); #1;
    lut_we_m = 1'b0;
    chk("hazard_old_target", inst_addr_m, 11);
    @(posedge clk); #1;
    chk("hazard_new_target", inst_addr_m, 20);
    @(posedge clk); #1;
    chk("hazard_done", done_m, 1);
    chk("hazard_halt_addr", inst_addr_m, 20);
    chk("hazard_count", cycle_count_m, 3);

    // watchdog with wrap on the small instance: all-zero ROM
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    chk("wd_start_addr", inst_addr_s, 0);
    for (int k = 1; k <= 15; k++) begin
      sb.push_back(k % 8);
      @(posedge clk); #1;
      chk("wd_wrap_addr", inst_addr_s, sb.pop_front());
    end
    chk("wd_not_yet_done", done_s, 0);
    chk("wd_still_running", running_s, 1);
    @(posedge clk); #1;
    chk("wd_done", done_s, 1);
    chk("wd_timeout", timeout_s, 1);
    chk("wd_running", running_s, 0);
    chk("wd_count", cycle_count_s, 16);

    // halt on the same cycle the watchdog would fire: halt wins
    lut_write_s(3'd0, 3'd7);
    rom_s[7] = 9'o700;
    zero_s = 1'b0;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    chk("wd2_timeout_cleared", timeout_s, 0);
    chk("wd2_done_cleared", done_s, 0);
    for (int k = 1; k <= 15; k++) begin
      sb.push_back(k % 8);
      @(posedge clk); #1;
      chk("wd2_addr", inst_addr_s, sb.pop_front());
    end
    zero_s = 1'b1;
    @(posedge clk); #1;
    zero_s = 1'b0;
    chk("tie_done", done_s, 1);
    chk("tie_timeout", timeout_s, 0);
    chk("tie_addr", inst_addr_s, 7);
    chk("tie_count", cycle_count_s, 16);

    // reset mid-run at address 9 clears state and the LUT
    for (int i = 0; i < 128; i++) rom_m[i] = 9'o000;
    lut_write_m(3'd1, 7'd33);
    start_m_pulse();
    for (int k = 0; k < 40 && inst_addr_m != 7'd9; k++) begin
      @(posedge clk); #1;
    end
    chk("reach_addr9", inst_addr_m, 9);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun_rst_addr", inst_addr_m, 0);
    chk("midrun_rst_running", running_m, 0);
    chk("midrun_rst_count", cycle_count_m, 0);
    chk("midrun_rst_done", done_m, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // with lut[1] cleared, BR 1 at address 0 branches to itself
    rom_m[0] = 9'o601;
    start_m_pulse();
    @(posedge clk); #1;
    chk("post_rst_done", done_m, 1);
    chk("post_rst_addr", inst_addr_m, 0);
    chk("post_rst_count", cycle_count_m, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch controller for the 9-bit accumulator-style core. It drives the 7-bit instruction ROM address and resolves BR/BRZ targets through a small writable branch lookup table. It detects the self-branch halt idiom and bounds runaway programs with a cycle watchdog. It sits between the testbench/top-level start/done handshake and the instruction ROM, with the zero flag supplied by the datapath.

## Interface
- ADDR_W, 7, instruction address width (ROM depth 2^ADDR_W)
- LUT_DEPTH, 8, branch LUT entries; the index is instr[2:0]
- TIMEOUT, 4096, maximum RUN cycles before a forced stop
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin execution from address 0
- instr_in  in  9  instruction currently addressed (combinational ROM output)
- zero_flag  in  1  registered datapath zero flag, valid in the branch cycle
- lut_we  in  1  branch LUT write enable
- lut_waddr  in  3  LUT entry to write
- lut_wdata  in  ADDR_W  branch target to store
- inst_addr  out  ADDR_W  program counter / ROM address
- running  out  1  high while in RUN
- done  out  1  high in DONE until the next accepted start
- timeout  out  1  high in DONE when the stop was forced by the watchdog
- cycle_count  out  16  RUN cycles executed in the current or last run

## Operation
- The reset is asynchronous and active-low. Clock domain is clk only.
- Reset values: state=IDLE, inst_addr=0, running=0, done=0, timeout=0, cycle_count=0, all LUT entries=0.
- States are IDLE, RUN and DONE.
- IDLE to RUN on start=1. On that edge: inst_addr←0, cycle_count←0, done←0, timeout←0.
- DONE to RUN on start=1, with identical clearing. DONE with no start holds all outputs.
- start is ignored in RUN.
- Decoding in RUN uses op=instr_in[8:6] and idx=instr_in[2:0]:
  - op=110 (BR): next=lut[idx].
  - op=111 (BRZ): next = zero_flag ? lut[idx] : inst_addr+1.
  - Any other op: next=inst_addr+1.
  - Increment wraps modulo 2^ADDR_W (127→0). No other action is taken on wrap.
- Halt: a taken branch with next==inst_addr is a halt.
  - Effect: state←DONE, done←1, inst_addr holds, cycle_count increments for that cycle.
- Watchdog: cycle_count increments on every RUN cycle.
  - If the increment would reach TIMEOUT and the current instruction is not a halt: state←DONE, done←1, timeout←1.
  - If the halt and the timeout limit fall on the same cycle, the halt wins and timeout=0.
- LUT write:
  - On lut_we, lut[lut_waddr]←lut_wdata at the edge. Writes are accepted in every state.
  - A branch in the same cycle as a write to its entry uses the old value. There is no bypass.
- Reset mid-RUN aborts immediately to the reset values. The LUT contents are lost and must be reloaded.
- running is a registered output: running = (state==RUN).

## Timing
- Start latency: start sampled high at edge k puts running=1 after edge k. ROM address 0 is presented in the first RUN cycle.
- One instruction per cycle. inst_addr updates at every RUN edge. Branches take one cycle with no bubble.
- instr_in and zero_flag are sampled at the same edge that updates inst_addr.
- done and timeout rise at the edge that ends the halting or last cycle. running falls at that same edge.
- After halt, cycle_count equals the number of instructions executed, including the halt.
- Timeout: done=1 after exactly TIMEOUT RUN cycles.
- A start arriving in the same cycle as done rising is ignored, because the state was RUN when it was sampled.

## Test plan
- Reset and idle: assert rst_n=0 mid-clock -> all outputs 0 immediately. No start for 20 cycles -> inst_addr stays 0.
- Straight line with halt: ROM holds 5 ALU ops, then BR 2 at address 5, with lut[2]=5 -> done after 6 RUN cycles, inst_addr=5, cycle_count=6, timeout=0.
- BRZ both ways: BRZ 1 at address 3 with lut[1]=10 -> zero_flag=1 gives next address 10; zero_flag=0 gives next address 4.
- Wrap and watchdog with TIMEOUT=16: ROM all zeros and start -> done after 16 cycles with timeout=1. With ADDR_W=3, inst_addr wraps 7→0.
- LUT hazard and restart: write lut[4]=20 in the same cycle as BR 4 with old lut[4]=11 -> jumps to 11, and the next BR 4 jumps to 20. After done, start -> flags clear and execution restarts at 0.
- Reset mid-run at inst_addr=9 -> inst_addr=0, LUT cleared, a subsequent start runs from 0.
